axis_stream_averaging_filter: RTL and testbench

AXIS_STREAM_AVERAGING_FILTER -- requirements
Module: axis_stream_averaging_filter

---
 rtl/axis_stream_averaging_filter.sv | 177 +++++++++++++++++
 tb/tb_axis_stream_averaging_filter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_averaging_filter.sv
// K x K box-average filter over a raster-order AXI-stream image.
// K-1 line buffers feed a K x K sliding window; each accepted pixel whose
// window lies fully inside the image yields one averaged output pixel.
// Only the valid region is emitted: (R_I-K+1) x (C_I-K+1) pixels per frame.
module axis_stream_averaging_filter #(
    parameter int R_I   = 7,
    parameter int C_I   = 7,
    parameter int W_I   = 8,
    parameter int K     = 3,
    parameter int ROUND = 0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           s_axis_valid,
    output logic           s_axis_ready,
    input  logic [W_I-1:0] s_axis_data,
    input  logic           s_axis_last,
    output logic           m_axis_valid,
    input  logic           m_axis_ready,
    output logic [W_I-1:0] m_axis_data,
    output logic           m_axis_last,
    output logic           frame_err,
    output logic           busy
);

    localparam int CW = (C_I > 1) ? $clog2(C_I) : 1;
    localparam int RW = (R_I > 1) ? $clog2(R_I) : 1;
    // K*K <= 25, so five extra bits hold the window sum without overflow
    localparam int SW = W_I + 5;

    localparam logic [SW-1:0] KK       = SW'(K * K);
    localparam logic [SW-1:0] RADD     = (ROUND != 0) ? SW'((K * K) / 2) : '0;
    localparam logic [CW-1:0] COL_LAST = CW'(C_I - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(R_I - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    logic accept;
    logic at_end;
    logic early_last;
    logic win_done;

    // lbuf[0] holds the previous row, lbuf[K-2] the oldest row in the window
    logic [W_I-1:0] lbuf [K-1][C_I];
    // win[r][c]: r = 0 is the oldest row, c = K-1 is the newest column
    logic [K-1:0][K-1:0][W_I-1:0] win;
    logic [K-1:0][W_I-1:0]        new_col;
    logic [SW-1:0]                sum;

    // Single output register: the input may advance whenever that register
    // is free or being emptied this cycle; held off completely during reset.
    assign s_axis_ready = rstn && (!m_axis_valid || m_axis_ready);
    assign accept       = s_axis_valid && s_axis_ready;
    assign at_end       = (row == ROW_LAST) && (col == COL_LAST);
    assign early_last   = accept && s_axis_last && !at_end;
    // An aborting pixel does not produce an output
    assign win_done     = accept && !early_last && (row >= ROW_WIN) && (col >= COL_WIN);

    // Column entering the window: buffered rows above plus the incoming pixel
    always_comb begin
        new_col[K-1] = s_axis_data;
        for (int i = 0; i < K - 1; i++) begin
            new_col[K-2-i] = lbuf[i][col];
        end
    end

    // Window sum after the shift: the K-1 surviving columns plus the new one
    always_comb begin
        sum = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 1; c < K; c++) begin
                sum = sum + SW'(win[r][c]);
            end
            sum = sum + SW'(new_col[r]);
        end
    end

    // Line buffers and window shift on every accept; contents never need
    // clearing since rows above K-2 are always rewritten before they are used
    always_ff @(posedge clk) begin
        if (accept) begin
            lbuf[0][col] <= s_axis_data;
            for (int i = 1; i < K - 1; i++) begin
                lbuf[i][col] <= lbuf[i-1][col];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= new_col[r];
            end
        end
    end

    // Raster position; advances only on accept, cleared by an early last
    always_ff @(posedge clk) begin
        if (!rstn) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (early_last) begin
                row <= '0;
                col <= '0;
            end else if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output register: load on a completed window, otherwise drain on ready
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
        end else if (win_done) begin
            m_axis_valid <= 1'b1;
            m_axis_data  <= W_I'((sum + RADD) / KK);
            m_axis_last  <= at_end;
        end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
        end
    end

    // Framing check: s_axis_last must coincide exactly with the final pixel
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && (s_axis_last != at_end);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state; an early last aborts the frame from any state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FILL;
            FILL:    if (accept && (row == ROW_WIN) && (col == '0)) state_nx = RUN;
            RUN:     if (accept && at_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (early_last) begin
            state_nx = IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE) || m_axis_valid;
    end

endmodule

// File: tb/tb_axis_stream_averaging_filter.sv
// Directed bench for axis_stream_averaging_filter at default geometry (7x7, K=3).
// A ROUND=1 twin shares the inputs so truncate and round-half-up are compared
// on the same window.
module tb_axis_stream_averaging_filter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic [7:0] s_data = '0;
    logic       m_ready = 1'b1;

    logic       s_ready, m_valid, m_last, frame_err, busy;
    logic [7:0] m_data;
    logic       r_sready, r_mvalid, r_mlast, r_err, r_busy;
    logic [7:0] r_data;

    int n_vec = 0;
    int n_bad = 0;
    int err_pulses = 0;
    bit stall_en = 1'b0;
    bit gap_en = 1'b0;

    logic [8:0] q[$];
    logic [7:0] qr[$];

    always #5 clk = ~clk;

    axis_stream_averaging_filter #(.R_I(7), .C_I(7), .W_I(8), .K(3), .ROUND(0)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_valid(s_valid), .s_axis_ready(s_ready), .s_axis_data(s_data), .s_axis_last(s_last),
        .m_axis_valid(m_valid), .m_axis_ready(m_ready), .m_axis_data(m_data), .m_axis_last(m_last),
        .frame_err(frame_err), .busy(busy)
    );

    axis_stream_averaging_filter #(.R_I(7), .C_I(7), .W_I(8), .K(3), .ROUND(1)) dut_r (
        .clk(clk), .rstn(rstn),
        .s_axis_valid(s_valid), .s_axis_ready(r_sready), .s_axis_data(s_data), .s_axis_last(s_last),
        .m_axis_valid(r_mvalid), .m_axis_ready(m_ready), .m_axis_data(r_data), .m_axis_last(r_mlast),
        .frame_err(r_err), .busy(r_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives m_ready on each falling edge and samples the outputs 2 time units later
    initial begin : monitor
        bit         prev_stall;
        logic       prev_err;
        logic [8:0] held;
        prev_stall = 1'b0;
        prev_err = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            m_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            #2;
            if (!rstn) begin
                prev_stall = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, m_valid}, 32'd1);
                    chk("stall_hold", {23'd0, m_last, m_data}, {23'd0, held});
                end
                if (m_valid && m_ready) begin
                    q.push_back({m_last, m_data});
                    qr.push_back(r_data);
                end
                prev_stall = m_valid && !m_ready;
                if (prev_stall) begin
                    held = {m_last, m_data};
                    chk("stall_no_accept", {31'd0, s_ready}, 32'd0);
                end
                if (frame_err) begin
                    err_pulses++;
                    chk("err_pulse_len", {31'd0, prev_err}, 32'd0);
                end
                prev_err = frame_err;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] d, input logic l, input int gap);
        int n;
        n = 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        #1;
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 1000) chk("accept_timeout", n, 0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    // kind 0: all 10; kind 1: row*7+col; kind 2: all 1 except (2,2)=6
    task automatic send_frame(input int kind, input int stop_at, input int last_at);
        int idx;
        logic [7:0] d;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                idx = r * 7 + c;
                if (idx <= stop_at) begin
                    case (kind)
                        0:       d = 8'd10;
                        1:       d = 8'(idx);
                        default: d = (idx == 16) ? 8'd6 : 8'd1;
                    endcase
                    push(d, idx == last_at, gap_en ? int'($urandom_range(0, 2)) : 0);
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", n, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_flat(input string tag);
        chk({tag, "_count"}, q.size(), 25);
        foreach (q[i]) begin
            chk({tag, "_data"}, {24'd0, q[i][7:0]}, 32'd10);
            chk({tag, "_last"}, {31'd0, q[i][8]}, (i == 24) ? 32'd1 : 32'd0);
        end
    endtask

    // Window centred on (i+1, j+1) of a linear ramp averages to the centre
    task automatic check_ramp(input string tag);
        chk({tag, "_count"}, q.size(), 25);
        foreach (q[i]) begin
            chk({tag, "_data"}, {24'd0, q[i][7:0]}, (i / 5 + 1) * 7 + (i % 5) + 1);
            chk({tag, "_last"}, {31'd0, q[i][8]}, (i == 24) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin : main
        // reset state
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 0);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_m_data", {24'd0, m_data}, 0);
        chk("rst_m_last", {31'd0, m_last}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, s_ready}, 1);
        @(negedge clk);

        // flat frame of 10s
        q.delete(); err_pulses = 0;
        send_frame(0, 48, 48);
        drain();
        check_flat("flat");
        chk("flat_err", err_pulses, 0);

        // ramp frame, free-flowing
        q.delete(); err_pulses = 0;
        send_frame(1, 48, 48);
        drain();
        check_ramp("ramp");
        chk("ramp_err", err_pulses, 0);

        // ramp frame with output stalls and input gaps
        stall_en = 1'b1; gap_en = 1'b1;
        q.delete(); err_pulses = 0;
        send_frame(1, 48, 48);
        drain();
        stall_en = 1'b0; gap_en = 1'b0;
        repeat (2) @(negedge clk);
        check_ramp("stall");
        chk("stall_err", err_pulses, 0);

        // S=14 in the first window: truncate -> 1, round half up -> 2
        q.delete(); qr.delete(); err_pulses = 0;
        send_frame(2, 48, 48);
        drain();
        chk("round_count", q.size(), 25);
        if (q.size() > 0) begin
            chk("trunc_first", {24'd0, q[0][7:0]}, 1);
            chk("round_first", {24'd0, qr[0]}, 2);
        end
        chk("round_twin_idle", {31'd0, r_busy}, 0);

        // early last on (3,2): abort, one error pulse, no output last
        q.delete(); err_pulses = 0;
        send_frame(0, 23, 23);
        drain();
        chk("early_count", q.size(), 5);
        chk("early_err", err_pulses, 1);
        foreach (q[i]) chk("early_no_last", {31'd0, q[i][8]}, 0);
        q.delete(); err_pulses = 0;
        send_frame(1, 48, 48);
        drain();
        check_ramp("after_early");
        chk("after_early_err", err_pulses, 0);

        // missing last: error pulse but frame still completes with m_axis_last
        q.delete(); err_pulses = 0;
        send_frame(1, 48, -1);
        drain();
        check_ramp("nolast");
        chk("nolast_err", err_pulses, 1);

        // reset for one cycle after pixel (4,4)
        send_frame(1, 32, -1);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_m_valid", {31'd0, m_valid}, 0);
        chk("midrst_m_data", {24'd0, m_data}, 0);
        chk("midrst_m_last", {31'd0, m_last}, 0);
        chk("midrst_frame_err", {31'd0, frame_err}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_s_ready", {31'd0, s_ready}, 0);
        rstn = 1'b1;
        @(negedge clk);
        q.delete(); err_pulses = 0;
        send_frame(0, 48, 48);
        drain();
        check_flat("after_rst");
        chk("after_rst_err", err_pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
